// File: rtl/hazard_stall_if.sv
// Pipeline-hazard handshake bundle: ID/EX/MEM register fields and cache-busy flags in,
// stall/flush/bubble controls and perf counters out.
interface hazard_stall_if;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        IF_ID_jalr;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_regwrite;
  logic        ID_EX_memread;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_memread;
  logic        redirect;
  logic        icache_stall;
  logic        dcache_stall;
  logic        PC_write;
  logic        IF_ID_write;
  logic        IF_ID_flush;
  logic        ID_EX_bubble;
  logic        pipe_freeze;
  logic [1:0]  ctrl_state;
  logic [15:0] lu_stall_cnt;
  logic [15:0] mem_stall_cnt;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_jalr, ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
           EX_MEM_rd, EX_MEM_memread, redirect, icache_stall, dcache_stall,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze, ctrl_state,
           lu_stall_cnt, mem_stall_cnt
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_jalr, ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
           EX_MEM_rd, EX_MEM_memread, redirect, icache_stall, dcache_stall,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze, ctrl_state,
           lu_stall_cnt, mem_stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use and JALR interlocks, cache freeze with deferred redirect flush.
// Define HAZARD_PERF_EN to build the saturating stall performance counters (tied to 0 otherwise).
module hazard_stall_ctrl (
  input  logic clk,
  input  logic rst_n,
  hazard_stall_if.slave bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FREEZE     = 2'd1,
    FLUSH_PEND = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   pend_q, pend_d;

  logic cache_stall, lu_haz, jr_haz, hazard, run_cycle;
  logic pc_w, ifid_w, flush, bubble, freeze;

  assign cache_stall = bus.icache_stall | bus.dcache_stall;

  assign lu_haz = bus.ID_EX_memread && (bus.ID_EX_rd != 5'd0) &&
                  ((bus.ID_EX_rd == bus.IF_ID_rs1) || (bus.ID_EX_rd == bus.IF_ID_rs2));

  // JALR reads rs1 in ID, so both an EX writer and a MEM-stage load interlock it.
  assign jr_haz = bus.IF_ID_jalr && (bus.IF_ID_rs1 != 5'd0) &&
                  ((bus.ID_EX_regwrite && (bus.ID_EX_rd == bus.IF_ID_rs1)) ||
                   (bus.EX_MEM_memread && (bus.EX_MEM_rd == bus.IF_ID_rs1)));

  assign hazard = lu_haz | jr_haz;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pc_w      = 1'b0;
    ifid_w    = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;
    freeze    = 1'b0;
    run_cycle = 1'b0;

    case (state_q)
      RUN: begin
        if (cache_stall) begin
          freeze  = 1'b1;
          state_d = FREEZE;
          pend_d  = bus.redirect;
        end else begin
          run_cycle = 1'b1;
        end
      end
      FREEZE: begin
        if (cache_stall) begin
          freeze = 1'b1;
          pend_d = pend_q | bus.redirect;
        end else if (pend_q) begin
          // Hold the front end one more cycle; the flush fires from FLUSH_PEND.
          state_d = FLUSH_PEND;
        end else begin
          run_cycle = 1'b1;
          state_d   = RUN;
        end
      end
      FLUSH_PEND: begin
        if (cache_stall) begin
          freeze  = 1'b1;
          state_d = FREEZE;
          pend_d  = 1'b1;
        end else begin
          flush   = 1'b1;
          pc_w    = 1'b1;
          ifid_w  = 1'b1;
          state_d = RUN;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
        pend_d  = 1'b0;
      end
    endcase

    if (run_cycle) begin
      if (bus.redirect) begin
        pc_w   = 1'b1;
        ifid_w = 1'b1;
        flush  = 1'b1;
        bubble = hazard;
      end else if (hazard) begin
        bubble = 1'b1;
      end else begin
        pc_w   = 1'b1;
        ifid_w = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Controls are combinational, so gate them to keep the pipeline quiet while in reset.
  assign bus.PC_write     = rst_n & pc_w;
  assign bus.IF_ID_write  = rst_n & ifid_w;
  assign bus.IF_ID_flush  = rst_n & flush;
  assign bus.ID_EX_bubble = rst_n & bubble;
  assign bus.pipe_freeze  = rst_n & freeze;
  assign bus.ctrl_state   = state_q;

`ifdef HAZARD_PERF_EN
  logic        lu_stall;
  logic [15:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;

  assign lu_stall = run_cycle & ~bus.redirect & hazard;

  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (lu_stall && (lu_cnt_q != 16'hFFFF))
      lu_cnt_d = lu_cnt_q + 16'd1;
    if (freeze && (mem_cnt_q != 16'hFFFF))
      mem_cnt_d = mem_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q  <= 16'd0;
      mem_cnt_q <= 16'd0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign bus.lu_stall_cnt  = lu_cnt_q;
  assign bus.mem_stall_cnt = mem_cnt_q;
`else
  assign bus.lu_stall_cnt  = 16'd0;
  assign bus.mem_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed + randomized bench for hazard_stall_ctrl against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_if bus();

  hazard_stall_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: is the pipe held by a cache miss, is a redirect owed, is the flush due now.
  bit m_frozen, m_owed, m_flush_due;
  int m_lu_cnt, m_mem_cnt;

  // Last observed outputs, for sequence-level checks.
  logic o_pc, o_ifw, o_flush, o_bub, o_frz;
  logic [1:0] o_state;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.IF_ID_rs1 = 5'd0; bus.IF_ID_rs2 = 5'd0; bus.IF_ID_jalr = 1'b0;
    bus.ID_EX_rd = 5'd0; bus.ID_EX_regwrite = 1'b0; bus.ID_EX_memread = 1'b0;
    bus.EX_MEM_rd = 5'd0; bus.EX_MEM_memread = 1'b0;
    bus.redirect = 1'b0; bus.icache_stall = 1'b0; bus.dcache_stall = 1'b0;
  endtask

  // One clock: check outputs at the negedge against the model, then advance the model at the edge.
  task automatic cycle(input string tag);
    bit cache, lu, jr, hz;
    bit e_pc, e_ifw, e_flush, e_bub, e_frz;
    int e_state;
    if (!rst_n) begin
      m_frozen = 0; m_owed = 0; m_flush_due = 0; m_lu_cnt = 0; m_mem_cnt = 0;
    end
    @(negedge clk);
    cache = bus.icache_stall | bus.dcache_stall;
    lu = bus.ID_EX_memread && bus.ID_EX_rd != 0 &&
         (bus.ID_EX_rd == bus.IF_ID_rs1 || bus.ID_EX_rd == bus.IF_ID_rs2);
    jr = bus.IF_ID_jalr && bus.IF_ID_rs1 != 0 &&
         ((bus.ID_EX_regwrite && bus.ID_EX_rd == bus.IF_ID_rs1) ||
          (bus.EX_MEM_memread && bus.EX_MEM_rd == bus.IF_ID_rs1));
    hz = lu | jr;
    {e_pc, e_ifw, e_flush, e_bub, e_frz} = 5'b0;
    if (!rst_n) begin
      // everything quiet
    end else if (cache) begin
      e_frz = 1;
    end else if (m_flush_due) begin
      e_flush = 1; e_pc = 1; e_ifw = 1;
    end else if (m_frozen && m_owed) begin
      // release cycle with a redirect owed: hold, flush next cycle
    end else if (bus.redirect) begin
      e_pc = 1; e_ifw = 1; e_flush = 1; e_bub = hz;
    end else if (hz) begin
      e_bub = 1;
    end else begin
      e_pc = 1; e_ifw = 1;
    end
    e_state = (!rst_n) ? 0 : m_flush_due ? 2 : m_frozen ? 1 : 0;

    o_pc = bus.PC_write; o_ifw = bus.IF_ID_write; o_flush = bus.IF_ID_flush;
    o_bub = bus.ID_EX_bubble; o_frz = bus.pipe_freeze; o_state = bus.ctrl_state;
    chk({tag, ".PC_write"},     16'(o_pc),    16'(e_pc));
    chk({tag, ".IF_ID_write"},  16'(o_ifw),   16'(e_ifw));
    chk({tag, ".IF_ID_flush"},  16'(o_flush), 16'(e_flush));
    chk({tag, ".ID_EX_bubble"}, 16'(o_bub),   16'(e_bub));
    chk({tag, ".pipe_freeze"},  16'(o_frz),   16'(e_frz));
    chk({tag, ".ctrl_state"},   16'(o_state), 16'(e_state));
    chk({tag, ".lu_stall_cnt"}, bus.lu_stall_cnt,  16'(m_lu_cnt));
    chk({tag, ".mem_stall_cnt"}, bus.mem_stall_cnt, 16'(m_mem_cnt));

    if (rst_n) begin
`ifdef HAZARD_PERF_EN
      if (e_bub && !e_pc && m_lu_cnt < 65535) m_lu_cnt++;
      if (e_frz && m_mem_cnt < 65535) m_mem_cnt++;
`endif
      if (cache) begin
        m_owed = m_owed | bus.redirect | m_flush_due;
        m_frozen = 1; m_flush_due = 0;
      end else if (m_flush_due) begin
        m_flush_due = 0; m_owed = 0; m_frozen = 0;
      end else if (m_frozen && m_owed) begin
        m_flush_due = 1; m_frozen = 0; m_owed = 0;
      end else begin
        m_frozen = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int stalls, flushes, freezes;

  initial begin
    idle();
    rst_n = 1'b0;
    m_frozen = 0; m_owed = 0; m_flush_due = 0; m_lu_cnt = 0; m_mem_cnt = 0;
    @(posedge clk); #1;
    cycle("reset0");
    cycle("reset1");
    rst_n = 1'b1;
    cycle("idle");

    // Load-use on rs2: exactly one stall cycle.
    bus.ID_EX_memread = 1; bus.ID_EX_regwrite = 1; bus.ID_EX_rd = 5'd5; bus.IF_ID_rs2 = 5'd5;
    cycle("loaduse");
    chk("loaduse.stall_pc", 16'(o_pc), 16'd0);
    chk("loaduse.stall_bub", 16'(o_bub), 16'd1);
    idle(); bus.EX_MEM_rd = 5'd5; bus.EX_MEM_memread = 1; bus.IF_ID_rs2 = 5'd5;
    cycle("loaduse_after");
    chk("loaduse.resume", 16'(o_pc), 16'd1);

    // Load feeding JALR: 2 stall cycles as the load moves EX -> MEM -> WB.
    stalls = 0;
    idle(); bus.IF_ID_jalr = 1; bus.IF_ID_rs1 = 5'd7;
    bus.ID_EX_rd = 5'd7; bus.ID_EX_memread = 1; bus.ID_EX_regwrite = 1;
    cycle("jalr_ld0"); stalls += int'(!o_pc);
    idle(); bus.IF_ID_jalr = 1; bus.IF_ID_rs1 = 5'd7; bus.EX_MEM_rd = 5'd7; bus.EX_MEM_memread = 1;
    cycle("jalr_ld1"); stalls += int'(!o_pc);
    idle(); bus.IF_ID_jalr = 1; bus.IF_ID_rs1 = 5'd7;
    cycle("jalr_ld2"); stalls += int'(!o_pc);
    chk("jalr_load.stall_cycles", 16'(stalls), 16'd2);

    // ALU result feeding JALR: 1 stall cycle.
    stalls = 0;
    idle(); bus.IF_ID_jalr = 1; bus.IF_ID_rs1 = 5'd9; bus.ID_EX_rd = 5'd9; bus.ID_EX_regwrite = 1;
    cycle("jalr_alu0"); stalls += int'(!o_pc);
    idle(); bus.IF_ID_jalr = 1; bus.IF_ID_rs1 = 5'd9; bus.EX_MEM_rd = 5'd9;
    cycle("jalr_alu1"); stalls += int'(!o_pc);
    chk("jalr_alu.stall_cycles", 16'(stalls), 16'd1);

    // x0 never interlocks.
    idle(); bus.ID_EX_memread = 1; bus.ID_EX_regwrite = 1; bus.ID_EX_rd = 5'd0;
    bus.IF_ID_rs1 = 5'd0; bus.IF_ID_jalr = 1;
    cycle("x0");
    chk("x0.no_stall", 16'(o_pc), 16'd1);

    // Redirect overrides a same-cycle load-use stall.
    idle(); bus.ID_EX_memread = 1; bus.ID_EX_rd = 5'd3; bus.IF_ID_rs1 = 5'd3; bus.redirect = 1;
    cycle("redir_haz");
    idle(); cycle("idle2");

    // Deferred flush: dcache 4 cycles, redirect in cycle 2.
    flushes = 0; freezes = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); bus.dcache_stall = 1; bus.redirect = (i == 1);
      cycle("defer_frz"); freezes += int'(o_frz); flushes += int'(o_flush);
    end
    idle(); cycle("defer_rel");
    chk("defer.rel_state", 16'(o_state), 16'd1); flushes += int'(o_flush);
    cycle("defer_flush");
    chk("defer.flush_state", 16'(o_state), 16'd2); flushes += int'(o_flush);
    cycle("defer_run");
    chk("defer.run_state", 16'(o_state), 16'd0); flushes += int'(o_flush);
    chk("defer.freeze_cycles", 16'(freezes), 16'd4);
    chk("defer.flush_pulses", 16'(flushes), 16'd1);

    // Cache stall arriving in FLUSH_PEND keeps the flush owed.
    idle(); bus.icache_stall = 1; bus.redirect = 1; cycle("fp_frz");
    idle(); cycle("fp_rel");
    bus.dcache_stall = 1; cycle("fp_restall0"); cycle("fp_restall1");
    idle(); cycle("fp_rel2"); cycle("fp_flush"); cycle("fp_run");

    // Reset mid-FREEZE with a latched redirect: no flush afterwards.
    idle(); bus.dcache_stall = 1; bus.redirect = 1; cycle("rst_frz0");
    bus.redirect = 0; cycle("rst_frz1");
    rst_n = 1'b0; cycle("rst_mid");
    rst_n = 1'b1; idle();
    flushes = 0;
    for (int i = 0; i < 5; i++) begin
      cycle("rst_after"); flushes += int'(o_flush);
    end
    chk("rst_mid.no_flush", 16'(flushes), 16'd0);
    chk("rst_mid.mem_cnt", bus.mem_stall_cnt, 16'd0);

    // Randomized traffic, including occasional async reset.
    for (int i = 0; i < 3000; i++) begin
      bus.IF_ID_rs1 = 5'($urandom_range(0, 7));
      bus.IF_ID_rs2 = 5'($urandom_range(0, 7));
      bus.IF_ID_jalr = ($urandom_range(0, 3) == 0);
      bus.ID_EX_rd = 5'($urandom_range(0, 7));
      bus.ID_EX_regwrite = 1'($urandom);
      bus.ID_EX_memread = 1'($urandom);
      bus.EX_MEM_rd = 5'($urandom_range(0, 7));
      bus.EX_MEM_memread = 1'($urandom);
      bus.redirect = ($urandom_range(0, 5) == 0);
      bus.icache_stall = ($urandom_range(0, 7) == 0);
      bus.dcache_stall = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      cycle("rand");
    end
    rst_n = 1'b1;

    // Long freeze for counter saturation.
    idle(); bus.dcache_stall = 1;
    for (int i = 0; i < 70000; i++) cycle("sat");
    idle(); cycle("sat_end");
`ifdef HAZARD_PERF_EN
    chk("sat.mem_cnt", bus.mem_stall_cnt, 16'hFFFF);
`else
    chk("sat.mem_cnt", bus.mem_stall_cnt, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
